// File: rtl/fifo_27_drain.sv
// fifo_27_drain: read-side consumer for the 27-bit async FIFO (read clock domain).
// Issues FIFO reads against a credit limit, absorbs the FIFO's fixed read
// latency, and buffers words in a small skid buffer. The head word is presented
// as a split {addr, data} record on a valid/ready stream.
// Ports:
//   clk, rst_n          FIFO read clock, async active-low reset
//   enable              permit new FIFO reads (low = stop and drain)
//   fifo_dout/empty     FIFO read data / empty flag
//   fifo_rd_en          FIFO read enable
//   out_addr/out_data   head word fields, out_valid/out_ready handshake
//   idle                registered, high when stopped with nothing pending
//   words_drained       count of accepted output words (wraps)
module fifo_27_drain #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 10,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [26:0]       fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              idle,
  output logic [31:0]       words_drained
);

  generate
    if (ADDR_W + DATA_W != 27) begin : g_bad_split
      $error("fifo_27_drain: ADDR_W + DATA_W must equal 27");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_lat
      $error("fifo_27_drain: RD_LATENCY must be 1 or 2");
    end
    if (BUF_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
      $error("fifo_27_drain: BUF_DEPTH must be >= RD_LATENCY+1");
    end
  endgenerate

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  rec_t [BUF_DEPTH-1:0] buf_q;
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     occ_q, occ_nxt, infl, infl_nxt;
  // vld_pipe[i] set = a read issued i cycles ago; the top bit is the capture strobe
  logic [RD_LATENCY:1]  vld_pipe;
  logic                 cap, pop;
  state_t               state_q, state_nxt;

  function automatic logic [PTR_W-1:0] nxt_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign cap       = vld_pipe[RD_LATENCY];
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_addr  = buf_q[head_q].addr;
  assign out_data  = buf_q[head_q].data;

  always_comb begin
    infl = '0;
    for (int i = 1; i <= RD_LATENCY; i++) infl = infl + CNT_W'(vld_pipe[i]);
    occ_nxt  = occ_q + CNT_W'(cap) - CNT_W'(pop);
    infl_nxt = infl - CNT_W'(cap) + CNT_W'(fifo_rd_en);
  end

  // state register + datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idle          <= 1'b1;
      occ_q         <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      vld_pipe      <= '0;
      buf_q         <= '0;
      words_drained <= '0;
    end else begin
      state_q <= state_nxt;
      idle    <= (state_nxt == IDLE);
      vld_pipe[1] <= fifo_rd_en;
      for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      occ_q <= occ_nxt;
      if (cap) begin
        // credit rule should make this unreachable
        if (!pop) assert (occ_q != FULL_C);
        buf_q[tail_q] <= rec_t'(fifo_dout);
        tail_q        <= nxt_ptr(tail_q);
      end
      if (pop) begin
        head_q        <= nxt_ptr(head_q);
        words_drained <= words_drained + 32'd1;
      end
    end
  end

  // next state; DRAIN->IDLE looks at post-edge counts so idle rises right
  // after the last word leaves
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN:   if (enable) state_nxt = RUN;
               else if (occ_nxt == '0 && infl_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: read issue against buffer credit (buffered + in flight)
  always_comb begin
    fifo_rd_en = rst_n & enable & ~fifo_empty &
                 (({1'b0, occ_q} + {1'b0, infl}) < DEPTH_C);
  end

endmodule

// File: tb/tb_fifo_27_drain.sv
// Directed bench for fifo_27_drain (default parameters, RD_LATENCY=1, BUF_DEPTH=4).
// A small behavioural FIFO with one-cycle read latency feeds the DUT; a monitor
// logs every output transfer for in-order checks.
module tb_fifo_27_drain;
  logic        clk = 1'b0;
  logic        rst_n, enable, fifo_empty, fifo_rd_en, out_valid, out_ready, idle;
  logic [26:0] fifo_dout = '0;
  logic [16:0] out_addr;
  logic [9:0]  out_data;
  logic [31:0] words_drained;

  int checks = 0;
  int errors = 0;

  logic [26:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rd_cnt = 0;
  logic [26:0] rx [$];

  fifo_27_drain dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .out_addr(out_addr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .idle(idle), .words_drained(words_drained)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // upstream FIFO model: data valid one cycle after the read enable
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      rd_cnt    <= rd_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) rx.push_back({out_addr, out_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [26:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] mk(input logic [16:0] a, input logic [9:0] d);
    return {a, d};
  endfunction

  function automatic logic [26:0] bp(input int i);
    return mk(17'(i + 3), 10'(i * 7 + 5));
  endfunction

  initial begin
    logic [9:0] rd_bits;
    int snap, base, gaps, n;
    logic [26:0] d_w [4];
    logic [26:0] r_w [6];

    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_addr",  32'(out_addr), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_count", words_drained, 0);
    chk("rst_idle",  32'(idle), 1);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    rst_n = 1'b1;
    step();

    // stream of 8 words, ready high
    for (int w = 1; w <= 8; w++) push(27'(w));
    enable = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      rd_bits[i] = fifo_rd_en;
      chk("seq_valid", 32'(out_valid), (i >= 2) ? 1 : 0);
      if (i >= 2) begin
        chk("seq_data", 32'(out_data), 32'(i - 1));
        chk("seq_addr", 32'(out_addr), 0);
      end
      step();
    end
    chk("seq_rd_en_pattern", 32'(rd_bits), 32'h0FF);
    chk("seq_count", words_drained, 8);
    chk("seq_idle", 32'(idle), 0);

    // field split boundaries
    push(27'h7FFFFFF);
    push(27'h4000400);
    for (n = 0; n < 10 && !out_valid; n++) step();
    chk("split_timeout", 32'(out_valid), 1);
    chk("split_a_addr", 32'(out_addr), 32'h1FFFF);
    chk("split_a_data", 32'(out_data), 32'h3FF);
    step();
    chk("split_b_valid", 32'(out_valid), 1);
    chk("split_b_addr", 32'(out_addr), 32'h10001);
    chk("split_b_data", 32'(out_data), 32'h000);
    step();

    // backpressure: only BUF_DEPTH reads issue
    out_ready = 1'b0;
    snap = rd_cnt;
    for (int i = 0; i < 20; i++) push(bp(i));
    repeat (8) step();
    chk("bp_reads", 32'(rd_cnt - snap), 4);
    chk("bp_rd_en", 32'(fifo_rd_en), 0);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_head", {5'd0, out_addr, out_data}, 32'(bp(0)));
    repeat (3) step();
    chk("bp_hold", {5'd0, out_addr, out_data}, 32'(bp(0)));
    base = rx.size();
    out_ready = 1'b1;
    gaps = 0;
    for (n = 0; n < 40 && rx.size() < base + 20; n++) begin
      step();
      if (rx.size() < base + 20 && !out_valid) gaps++;
    end
    chk("bp_drain_count", 32'(rx.size() - base), 20);
    chk("bp_gaps", 32'(gaps), 0);
    for (int i = 0; i < 20 && base + i < rx.size(); i++)
      chk("bp_order", 32'(rx[base + i]), 32'(bp(i)));

    // enable falls with 2 buffered + 1 in flight
    d_w[0] = mk(17'h00AAA, 10'h155);
    d_w[1] = mk(17'h15555, 10'h2AA);
    d_w[2] = mk(17'h0F0F0, 10'h0F0);
    d_w[3] = mk(17'h12345, 10'h321);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(d_w[i]);
    step();
    step();
    step();
    enable = 1'b0;
    #1;
    chk("drain_rd_en_off", 32'(fifo_rd_en), 0);
    chk("drain_head", {5'd0, out_addr, out_data}, 32'(d_w[0]));
    snap = rd_cnt;
    base = rx.size();
    out_ready = 1'b1;
    step();
    chk("drain_w1", {5'd0, out_addr, out_data}, 32'(d_w[1]));
    chk("drain_idle_a", 32'(idle), 0);
    step();
    chk("drain_w2", {5'd0, out_addr, out_data}, 32'(d_w[2]));
    chk("drain_idle_b", 32'(idle), 0);
    step();
    chk("drain_valid_end", 32'(out_valid), 0);
    chk("drain_idle_end", 32'(idle), 1);
    chk("drain_no_reads", 32'(rd_cnt - snap), 0);
    chk("drain_count", 32'(rx.size() - base), 3);

    // asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) begin
      r_w[i] = mk(17'(16'hA000 + i), 10'(10'h200 + i));
      push(r_w[i]);
    end
    enable = 1'b1;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_addr",  32'(out_addr), 0);
    chk("arst_data",  32'(out_data), 0);
    chk("arst_count", words_drained, 0);
    chk("arst_rd_en", 32'(fifo_rd_en), 0);
    chk("arst_idle",  32'(idle), 1);
    base = rx.size();
    #2 rst_n = 1'b1;
    for (n = 0; n < 20 && rx.size() < base + 4; n++) step();
    step();
    chk("arst_post_count", 32'(rx.size() - base), 4);
    for (int i = 0; i < 4 && base + i < rx.size(); i++)
      chk("arst_order", 32'(rx[base + i]), 32'(r_w[i + 2]));
    chk("arst_drained", words_drained, 4);

    // counter wrap
    force dut.words_drained = 32'hFFFF_FFFE;
    #1;
    release dut.words_drained;
    #1;
    chk("wrap_preload", words_drained, 32'hFFFF_FFFE);
    base = rx.size();
    for (int i = 0; i < 3; i++) push(27'(27'h100 + i));
    for (n = 0; n < 20 && rx.size() < base + 3; n++) step();
    step();
    chk("wrap_xfers", 32'(rx.size() - base), 3);
    chk("wrap_count", words_drained, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_27_drain.md
Name: fifo_27_drain

Overview:
- Read-side consumer placed directly downstream of the 27-bit async FIFO, in the read-clock domain.
- Issues FIFO read enables, absorbs the FIFO's fixed read latency, and presents each word as a split {addr, data} record on a valid/ready stream toward the framebuffer writer.
- Provides sustained 1 word/cycle throughput, a clean stop/drain via enable, and a running drained-word count.

Parameters:
- ADDR_W, 17, address field width; taken from word bits [26:DATA_W].
- DATA_W, 10, data field width; taken from word bits [DATA_W-1:0]. ADDR_W+DATA_W must equal 27; elaboration error otherwise.
- RD_LATENCY, 1, cycles from fifo_rd_en high to fifo_dout valid (1 or 2).
- BUF_DEPTH, 4, internal skid-buffer entries; must be >= RD_LATENCY+1.

Ports:
- clk  in  1  single clock; the FIFO read clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- enable  in  1  permit new FIFO reads.
- fifo_dout  in  27  FIFO read data.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read enable (drives the FIFO's read_valid).
- out_addr  out  ADDR_W  address field of the head word.
- out_data  out  DATA_W  data field of the head word.
- out_valid  out  1  head word is valid.
- out_ready  in  1  consumer accepts the head word.
- idle  out  1  no reads in flight, buffer empty, enable low.
- words_drained  out  32  count of accepted output words.

Behaviour:
- Reset (rst_n low, asynchronous): fifo_rd_en=0, out_valid=0, out_addr=0, out_data=0, words_drained=0, buffer and in-flight counters cleared, idle=1, state=IDLE. Takes effect immediately, including mid-transfer. In-flight FIFO words arriving after reset release are discarded; the in-flight counter was cleared, so no capture occurs.
- Credit rule: fifo_rd_en = enable & !fifo_empty & (occupancy + inflight < BUF_DEPTH).
  - occupancy = buffered words.
  - inflight = reads issued whose data has not yet arrived.
  - fifo_rd_en is combinational from registered state and inputs, and is 0 in reset.
- Capture: a read issued in cycle t writes fifo_dout sampled at the edge ending cycle t+RD_LATENCY into the buffer tail. A shift register of RD_LATENCY bits tracks the capture strobes.
- Output:
  - Buffer head drives out_addr/out_data; out_valid = occupancy != 0.
  - Transfer occurs when out_valid & out_ready; head pops on that edge.
  - Head fields are stable while out_valid & !out_ready.
- Simultaneous capture and pop in the same cycle: occupancy unchanged, no data loss or duplication.
- Capture into an empty buffer: out_valid rises the cycle after capture. Total latency from fifo_rd_en to out_valid is RD_LATENCY+1 cycles.
- Throughput: with out_ready held high, enable high and FIFO non-empty, one word per cycle once the pipeline fills. BUF_DEPTH >= RD_LATENCY+1 guarantees this.
- Backpressure: with out_ready low, reads stop once occupancy+inflight reaches BUF_DEPTH. The buffer never overflows. An internal assertion flags a capture into a full buffer.
- fifo_empty is honoured only at issue. Words already in flight are always captured.
- Field split: out_addr = word[26:DATA_W], out_data = word[DATA_W-1:0]. No arithmetic on either field.
- words_drained increments by 1 per output transfer and wraps from 2^32-1 to 0.
- State machine:
  - IDLE: enable=0 and nothing pending; idle=1. Moves to RUN when enable=1.
  - RUN: reads permitted. Moves to DRAIN when enable falls.
  - DRAIN: no new reads; in-flight words are still captured and the buffer continues to empty to the output. Moves to IDLE when occupancy=0 and inflight=0. Moves to RUN if enable returns high, with no loss of buffered words.
- idle is registered: idle=1 exactly in IDLE.

Test Plan:
- Reset then 8 words 0x0000001..0x0000008 in FIFO, enable=1, out_ready=1 -> fifo_rd_en high 8 consecutive cycles; first out_valid 2 cycles after first rd_en (RD_LATENCY=1); outputs in order 1..8 on consecutive cycles; words_drained=8; out_addr=0 and out_data=word[9:0] for each.
- Word 0x7FFFFFF -> out_addr=0x1FFFF, out_data=0x3FF; word 0x4000400 -> out_addr=0x10001, out_data=0x000.
- out_ready low with FIFO holding 20 words -> exactly BUF_DEPTH=4 reads issued, then fifo_rd_en=0; out_addr/out_data held. Raising out_ready drains all 20 in order with no gaps after refill.
- enable falls while 1 read is in flight and 2 words are buffered -> no further fifo_rd_en; all 3 words delivered; idle=1 one cycle after the last transfer.
- rst_n pulsed low mid-stream for one cycle (asynchronously, not clock-aligned) -> outputs zero immediately; the post-reset FIFO word from the stale read is not output; words_drained=0.
- words_drained preloaded via force to 0xFFFFFFFE, then 3 transfers -> reads 0x00000001.
